hazard_control_unit: RTL

- Pipeline sequencer for the 5-stage MIPS core.
- Decides each cycle whether the PC and IF/ID advance, and which stage registers (IF/ID, ID/EX, EX/MEM) are loaded with a bubble.
- Covers load-use hazards, taken branches resolved in MEM, jumps resolved in ID, and a multi-cycle mult/div unit with a busy counter.
- Sits beside the ID stage; drives the write-enable and flush inputs of the stage registers.

---
 rtl/mips_pipe_pkg.sv | 12 +
 rtl/hazard_control_unit_if.sv | 39 +++
 rtl/muldiv_busy_counter.sv | 64 ++++++
 rtl/hazard_control_unit.sv | 105 ++++++++++
 4 files changed

// File: rtl/mips_pipe_pkg.sv
// rtl/mips_pipe_pkg.sv - shared pipeline-control types and constants
package mips_pipe_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    BUSY = 1'b1
  } muldiv_state_t;

  localparam int REG_ZERO               = 0;
  localparam int DEFAULT_MULDIV_LATENCY = 32;

endpackage

// File: rtl/hazard_control_unit_if.sv
// rtl/hazard_control_unit_if.sv - ID-stage hazard inputs and stage-register controls
interface hazard_control_unit_if #(
  parameter int REG_ADDR_WIDTH = 5
);

  logic [REG_ADDR_WIDTH-1:0] id_rs;
  logic [REG_ADDR_WIDTH-1:0] id_rt;
  logic                      id_uses_rs;
  logic                      id_uses_rt;
  logic                      id_uses_hilo;
  logic                      id_muldiv_start;
  logic                      id_jump;
  logic                      ex_mem_read;
  logic [REG_ADDR_WIDTH-1:0] ex_rt;
  logic                      mem_branch_taken;

  logic                      pc_write;
  logic                      if_id_write;
  logic                      if_id_flush;
  logic                      id_ex_flush;
  logic                      ex_mem_flush;
  logic                      muldiv_busy;
  logic                      muldiv_done;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, id_uses_hilo, id_muldiv_start,
           id_jump, ex_mem_read, ex_rt, mem_branch_taken,
    input  pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush,
           muldiv_busy, muldiv_done
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_uses_hilo, id_muldiv_start,
           id_jump, ex_mem_read, ex_rt, mem_branch_taken,
    output pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush,
           muldiv_busy, muldiv_done
  );

endinterface

// File: rtl/muldiv_busy_counter.sv
// rtl/muldiv_busy_counter.sv - mult/div occupancy FSM with 8-bit countdown
module muldiv_busy_counter
  import mips_pipe_pkg::*;
#(
  parameter int MULDIV_LATENCY = DEFAULT_MULDIV_LATENCY
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy,
  output logic zero,
  output logic done
);

  localparam logic [7:0] RELOAD = 8'(MULDIV_LATENCY - 1);

  muldiv_state_t state, state_next;
  logic [7:0]    count, count_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      count <= 8'd0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // start is only raised by the parent when the unit is idle or finishing,
  // so a nonzero countdown never sees a reload.
  always_comb begin
    state_next = state;
    count_next = count;
    case (state)
      RUN: begin
        if (start) begin
          state_next = BUSY;
          count_next = RELOAD;
        end
      end
      BUSY: begin
        if (count == 8'd0) begin
          if (start) begin
            count_next = RELOAD;
          end else begin
            state_next = RUN;
          end
        end else begin
          count_next = count - 8'd1;
        end
      end
      default: begin
        state_next = RUN;
        count_next = 8'd0;
      end
    endcase
  end

  assign busy = (state == BUSY);
  assign zero = (count == 8'd0);
  assign done = busy && zero;

endmodule

// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - pipeline stall/flush sequencer; option HAZARD_PERF_COUNTERS_EN
module hazard_control_unit
  import mips_pipe_pkg::*;
#(
  parameter int MULDIV_LATENCY = DEFAULT_MULDIV_LATENCY,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 reset,
`ifdef HAZARD_PERF_COUNTERS_EN
  output logic [31:0]          perf_lu_stalls,
  output logic [31:0]          perf_md_stalls,
  output logic [31:0]          perf_flushes,
`endif
  hazard_control_unit_if.slave bus
);

  logic load_use;
  logic md_hazard;
  logic md_busy;
  logic md_zero;
  logic md_done;
  logic md_start;
  logic pc_write;
  logic if_id_write;
  logic if_id_flush;
  logic id_ex_flush;
  logic ex_mem_flush;

  assign load_use = bus.ex_mem_read
                 && (bus.ex_rt != REG_ADDR_WIDTH'(REG_ZERO))
                 && ((bus.id_uses_rs && (bus.id_rs == bus.ex_rt))
                  || (bus.id_uses_rt && (bus.id_rt == bus.ex_rt)));

  // On the final countdown cycle the result is forwarded, so no stall.
  assign md_hazard = md_busy && (bus.id_uses_hilo || bus.id_muldiv_start) && !md_zero;

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    md_start     = 1'b0;
    if (reset) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end else if (bus.mem_branch_taken) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end else if (md_hazard || load_use) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
    end else if (bus.id_jump) begin
      if_id_flush = 1'b1;
    end else begin
      md_start = bus.id_muldiv_start;
    end
  end

  muldiv_busy_counter #(
    .MULDIV_LATENCY (MULDIV_LATENCY)
  ) u_busy_counter (
    .clk   (clk),
    .reset (reset),
    .start (md_start),
    .busy  (md_busy),
    .zero  (md_zero),
    .done  (md_done)
  );

  assign bus.pc_write     = pc_write;
  assign bus.if_id_write  = if_id_write;
  assign bus.if_id_flush  = if_id_flush;
  assign bus.id_ex_flush  = id_ex_flush;
  assign bus.ex_mem_flush = ex_mem_flush;
  assign bus.muldiv_busy  = md_busy;
  assign bus.muldiv_done  = md_done;

`ifdef HAZARD_PERF_COUNTERS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_lu_stalls <= 32'd0;
      perf_md_stalls <= 32'd0;
      perf_flushes   <= 32'd0;
    end else begin
      if (!bus.mem_branch_taken && !md_hazard && load_use) begin
        perf_lu_stalls <= perf_lu_stalls + 32'd1;
      end
      if (!bus.mem_branch_taken && md_hazard) begin
        perf_md_stalls <= perf_md_stalls + 32'd1;
      end
      if (bus.mem_branch_taken) begin
        perf_flushes <= perf_flushes + 32'd1;
      end
    end
  end
`endif

endmodule
